ifid_skid_stage: RTL and testbench

Parametrised, handshaked successor to the fixed 16-bit IF/ID register. It carries a PC and an instruction word between two pipeline stages using a valid/ready handshake and a two-entry skid buffer. This gives full throughput with fully registered ready, plus synchronous flush and bubble insertion. Instances sit at IF/ID and can also be reused at ID/EX, EX/MEM and MEM/WB by widening the payload.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/ifid_skid_stage_if.sv | 24 ++
 rtl/pipe_sat_counter.sv | 16 +
 rtl/ifid_skid_stage.sv | 115 +++++++++++
 tb/tb_ifid_skid_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy state, default bubble word, payload layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int          DEF_PC_W     = 16;
    localparam int          DEF_INST_W   = 16;
    localparam logic [15:0] NOP_INST_DEF = 16'h0000;

    // Default-width payload; parametrised stages declare their own with the same field order.
    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_INST_W-1:0] inst;
    } payload_t;

endpackage

// File: rtl/ifid_skid_stage_if.sv
// Valid/ready bundle for one pipeline stage: upstream push side plus downstream pop side.
interface ifid_skid_stage_if #(
    parameter int PC_W   = 16,
    parameter int INST_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter, cleared only by synchronous active-low reset.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ifid_skid_stage.sv
// Two-entry skid-buffered pipeline register with flush and bubble insertion.
// Optional PERF_CNT_EN adds saturating stall/flush counters.
module ifid_skid_stage
    import pipe_pkg::*;
#(
    parameter int                PC_W     = 16,
    parameter int                INST_W   = 16,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
    parameter int                CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    ifid_skid_stage_if.slave bus
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } pl_t;

    localparam pl_t PL_NOP = '{pc: '0, inst: NOP_INST};

    state_t state_q, state_d;
    pl_t    main_q, main_d, skid_q, skid_d, in_pl;
    logic   in_ready_q, out_valid, in_fire, out_fire;

    assign in_pl    = '{pc: bus.in_pc, inst: bus.in_inst};
    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= PL_NOP;
            skid_q     <= PL_NOP;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Ready is a pure flop: it looks ahead at where the buffer will be.
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = PL_NOP;
            skid_d  = PL_NOP;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = in_pl;
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_pl;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_pl;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = PL_NOP;
                    end
                end
                ST_FULL: if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = PL_NOP;
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = PL_NOP;
                    skid_d  = PL_NOP;
                end
            endcase
        end
    end

    // Main register is forced to the bubble whenever empty, so outputs need no masking.
    always_comb begin
        out_valid     = (state_q != ST_EMPTY);
        bus.out_valid = out_valid;
        bus.out_pc    = main_q.pc;
        bus.out_inst  = main_q.inst;
        bus.in_ready  = in_ready_q;
    end

`ifdef PERF_CNT_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~bus.out_ready),
        .cnt (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush),
        .cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed + random bench for ifid_skid_stage against a queue-based occupancy model.
module tb_ifid_skid_stage;
    localparam int          PC_W   = 16;
    localparam int          INST_W = 16;
    localparam int          CNT_W  = 4;
    localparam int          CMAX   = (1 << CNT_W) - 1;
    localparam logic [15:0] NOP    = 16'h0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    ifid_skid_stage_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    ifid_skid_stage #(
        .PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } ent_t;

    ent_t q[$];
    bit   m_rdy = 1'b1;
    int   m_stall = 0;
    int   m_flush = 0;
    bit   acc_last;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, let the model take the same edge, compare all outputs.
    task automatic step(input logic v, input logic [15:0] pc, input logic [15:0] inst,
                        input logic ordy, input logic fl, input logic rs);
        bit   inf, outf;
        ent_t e;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = ordy;
        flush         = fl;
        rst           = rs;
        @(posedge clk);
        inf      = v && m_rdy;
        outf     = (q.size() > 0) && ordy;
        acc_last = inf && rs;
        if (!rs) begin
            q.delete();
            m_rdy   = 1'b1;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if ((q.size() > 0) && !ordy && (m_stall < CMAX)) m_stall++;
            if (fl) begin
                if (m_flush < CMAX) m_flush++;
                q.delete();
                m_rdy = 1'b1;
            end else begin
                if (outf) void'(q.pop_front());
                if (inf) begin
                    e.pc   = pc;
                    e.inst = inst;
                    q.push_back(e);
                end
                m_rdy = (q.size() < 2);
            end
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("in_ready",  32'(bus.in_ready),  32'(m_rdy));
        chk("out_pc",    32'(bus.out_pc),    (q.size() > 0) ? 32'(q[0].pc) : 32'h0);
        chk("out_inst",  32'(bus.out_inst),  (q.size() > 0) ? 32'(q[0].inst) : 32'(NOP));
`ifdef PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
        @(negedge clk);
    endtask

    initial begin
        bit          pend;
        logic        v, ordy, fl, rs;
        logic [15:0] pc, inst;

        // Reset
        step(0, 16'h0, 16'h0, 0, 0, 0);
        step(0, 16'h0, 16'h0, 0, 0, 0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_pc",    32'(bus.out_pc), 32'h0);
        chk("rst_inst",  32'(bus.out_inst), 32'(NOP));

        // Streaming, no bubbles
        for (int i = 1; i <= 3; i++) begin
            step(1, 16'(2 * i), 16'(16'h1000 + i), 1, 0, 1);
            chk("stream_pc", 32'(bus.out_pc), 32'(2 * i));
            chk("stream_vld", 32'(bus.out_valid), 32'h1);
        end
        step(0, 16'h0, 16'h0, 1, 0, 1);

        // Backpressure: A then B into a stalled stage
        step(1, 16'h00A0, 16'hAAAA, 0, 0, 1);
        step(1, 16'h00B0, 16'hBBBB, 0, 0, 1);
        chk("bp_full_rdy", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 16'h0, 16'h0, 0, 0, 1);
        chk("bp_hold_A", 32'(bus.out_pc), 32'h00A0);
        step(0, 16'h0, 16'h0, 1, 0, 1);
        chk("bp_then_B", 32'(bus.out_pc), 32'h00B0);
        chk("bp_rdy_back", 32'(bus.in_ready), 32'h1);
`ifdef PERF_CNT_EN
        chk("bp_stalls", 32'(stall_cnt), 32'd4);
`endif
        step(0, 16'h0, 16'h0, 1, 0, 1);

        // Flush in FULL while C is offered
        step(1, 16'h0120, 16'h1111, 0, 0, 1);
        step(1, 16'h0122, 16'h2222, 0, 0, 1);
        step(1, 16'h0C00, 16'hCCCC, 0, 1, 1);
        chk("fl_valid", 32'(bus.out_valid), 32'h0);
        chk("fl_ready", 32'(bus.in_ready), 32'h1);
`ifdef PERF_CNT_EN
        chk("fl_cnt", 32'(flush_cnt), 32'h1);
`endif
        step(0, 16'h0, 16'h0, 1, 0, 1);
        chk("fl_no_C", 32'(bus.out_valid), 32'h0);

        // Simultaneous in/out fire in ONE
        step(1, 16'h0100, 16'h5555, 1, 0, 1);
        step(1, 16'h0102, 16'h6666, 1, 0, 1);
        chk("sim_pc", 32'(bus.out_pc), 32'h0102);
        chk("sim_rdy", 32'(bus.in_ready), 32'h1);
        step(0, 16'h0, 16'h0, 1, 0, 1);

        // Long stall saturates the stall counter
        step(1, 16'h0200, 16'h7777, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 16'h0, 16'h0, 0, 0, 1);
`ifdef PERF_CNT_EN
        chk("sat_stall", 32'(stall_cnt), 32'(CMAX));
`endif
        step(0, 16'h0, 16'h0, 1, 0, 1);

        // Random traffic; upstream holds its payload until accepted
        pend = 1'b0;
        v = 1'b0; pc = '0; inst = '0;
        for (int n = 0; n < 500; n++) begin
            if (!pend) begin
                v    = ($urandom_range(0, 3) != 0);
                pc   = 16'($urandom);
                inst = 16'($urandom);
            end
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 29) == 0);
            rs   = ($urandom_range(0, 99) != 0);
            step(v, pc, inst, ordy, fl, rs);
            pend = v && rs && !acc_last;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
